// File: rtl/vga_scandoubler_pkg.sv
// Shared definitions for the line-doubling video stage: scanline modes,
// replay FSM states and the per-channel dimming helper.
package vga_scandoubler_pkg;

    localparam int MAX_CBITS = 8;

    typedef enum logic [1:0] {
        SCAN_NONE = 2'b00,
        SCAN_25   = 2'b01,
        SCAN_50   = 2'b10,
        SCAN_75   = 2'b11
    } scan_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS0 = 2'b01,
        PASS1 = 2'b10
    } fsm_state_t;

    // Truncating scanline attenuation; callers zero-extend narrower channels.
    function automatic logic [MAX_CBITS-1:0] dim(input logic [MAX_CBITS-1:0] c,
                                                 input scan_mode_t mode);
        logic [MAX_CBITS-1:0] r;
        case (mode)
            SCAN_25: r = c - (c >> 2);
            SCAN_50: r = c >> 1;
            SCAN_75: r = c >> 2;
            default: r = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/scandbl_linebuf.sv
// Simple dual-port line buffer: synchronous write, registered read (1 clk).
// The MSB of each address selects the ping-pong bank.
module scandbl_linebuf #(
    parameter int AW = 11,
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_scandoubler_gen2.sv
// Line doubler: captures each 15 kHz line into a ping-pong buffer and replays
// it twice at full clock rate with regenerated syncs and scanline dimming.
module vga_scandoubler_gen2
    import vga_scandoubler_pkg::*;
#(
    parameter int CBITS       = 3,
    parameter int ADDR_BITS   = 10,
    parameter int HSYNC_WIDTH = 106
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk14en,
    input  logic             enable_scandoubling,
    input  logic [1:0]       scan_mode,
    input  logic [CBITS-1:0] ri,
    input  logic [CBITS-1:0] gi,
    input  logic [CBITS-1:0] bi,
    input  logic             hsync_ext_n,
    input  logic             vsync_ext_n,
    input  logic             csync_ext_n,
    output logic [CBITS-1:0] ro,
    output logic [CBITS-1:0] go,
    output logic [CBITS-1:0] bo,
    output logic             hsync,
    output logic             vsync,
    output logic             overflow
);

    localparam int DW = 3 * CBITS;
    localparam int LW = ADDR_BITS + 1;

    logic             hs_prev;
    logic             hs_edge;
    logic             en_q;
    scan_mode_t       scan_q;
    logic             primed;
    logic [LW-1:0]    wcnt;
    logic [LW-1:0]    line_len;
    logic             wbank;
    fsm_state_t       state;
    logic [ADDR_BITS-1:0] rcnt;
    logic             last;
    logic             hs_low;
    logic             s1_active;
    logic             s1_hs;
    scan_mode_t       s1_dim;
    logic             vs_d1;
    logic             we;
    logic [ADDR_BITS:0] waddr;
    logic [ADDR_BITS:0] raddr;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rdata;

    function automatic logic [CBITS-1:0] dim_ch(input logic [CBITS-1:0] c,
                                                input scan_mode_t m);
        logic [MAX_CBITS-1:0] w;
        w = dim(MAX_CBITS'(c), m);
        return w[CBITS-1:0];
    endfunction

    assign hs_edge = hs_prev & ~hsync_ext_n;
    assign last    = ({1'b0, rcnt} == line_len - LW'(1));
    assign hs_low  = (32'(rcnt) < 32'(HSYNC_WIDTH));

    // An edge-coincident pixel lands at address 0 of the bank that opens now.
    assign we    = clk14en & (hs_edge | ~wcnt[ADDR_BITS]);
    assign waddr = hs_edge ? {~wbank, {ADDR_BITS{1'b0}}}
                           : {wbank, wcnt[ADDR_BITS-1:0]};
    assign wdata = {ri, gi, bi};
    assign raddr = {~wbank, rcnt};

    scandbl_linebuf #(
        .AW (ADDR_BITS + 1),
        .DW (DW)
    ) u_linebuf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Mode is only taken at line boundaries so a line is never torn.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev <= 1'b0;
            en_q    <= 1'b1;
            scan_q  <= SCAN_NONE;
            primed  <= 1'b0;
        end else begin
            hs_prev <= hsync_ext_n;
            if (hs_edge) begin
                en_q   <= enable_scandoubling;
                scan_q <= scan_mode_t'(scan_mode);
                primed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt     <= '0;
            line_len <= '0;
            wbank    <= 1'b0;
            overflow <= 1'b0;
        end else if (hs_edge) begin
            line_len <= wcnt;
            wbank    <= ~wbank;
            wcnt     <= clk14en ? LW'(1) : '0;
        end else if (clk14en) begin
            if (wcnt[ADDR_BITS]) begin
                overflow <= 1'b1;
            end else begin
                wcnt <= wcnt + LW'(1);
            end
        end
    end

    // The first edge after reset only measures a (possibly partial) line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= '0;
        end else if (hs_edge) begin
            rcnt  <= '0;
            state <= (primed && wcnt != '0) ? PASS0 : IDLE;
        end else begin
            case (state)
                PASS0: begin
                    if (last) begin
                        state <= PASS1;
                        rcnt  <= '0;
                    end else begin
                        rcnt <= rcnt + ADDR_BITS'(1);
                    end
                end
                PASS1: begin
                    if (last) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else begin
                        rcnt <= rcnt + ADDR_BITS'(1);
                    end
                end
                default: rcnt <= '0;
            endcase
        end
    end

    // Stage 1 tracks the RAM read; stage 2 is the pin register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_active <= 1'b0;
            s1_hs     <= 1'b0;
            s1_dim    <= SCAN_NONE;
            vs_d1     <= 1'b1;
            ro        <= '0;
            go        <= '0;
            bo        <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else begin
            s1_active <= (state != IDLE);
            s1_hs     <= hs_low;
            s1_dim    <= (state == PASS1) ? scan_q : SCAN_NONE;
            vs_d1     <= vsync_ext_n;
            if (!en_q) begin
                ro    <= ri;
                go    <= gi;
                bo    <= bi;
                hsync <= csync_ext_n;
                vsync <= 1'b1;
            end else if (s1_active) begin
                ro    <= dim_ch(rdata[DW-1 -: CBITS], s1_dim);
                go    <= dim_ch(rdata[2*CBITS-1 -: CBITS], s1_dim);
                bo    <= dim_ch(rdata[CBITS-1:0], s1_dim);
                hsync <= ~s1_hs;
                vsync <= vs_d1;
            end else begin
                ro    <= '0;
                go    <= '0;
                bo    <= '0;
                hsync <= 1'b1;
                vsync <= vs_d1;
            end
        end
    end

endmodule

// File: doc/vga_scandoubler_gen2.md
Name: vga_scandoubler_gen2

Overview:
Parametrised line-doubling video stage for the Spectrum core. It takes the 15 kHz PAL-timed RGB stream (one pixel per clk14en strobe on the 28 MHz system clock) and writes each line into a ping-pong line buffer. It replays every line twice at full clock rate with regenerated VGA syncs and a selectable scanline dimming depth. It also has a registered bypass for RGB/composite monitors, and replaces the fixed-width scandoubler between the core and the video DAC.

Parameters:
CBITS, 3, bits per colour channel
ADDR_BITS, 10, line buffer address width (max 2^ADDR_BITS pixels per line)
HSYNC_WIDTH, 106, output hsync low time in clk cycles (clamped to line length)

Ports:
clk  in  1  system clock (28 MHz)
rst  in  1  synchronous reset, active high
clk14en  in  1  input pixel strobe
enable_scandoubling  in  1  1=VGA doubling, 0=bypass
scan_mode  in  2  00 none, 01 -25%, 10 -50%, 11 -75% on second pass
ri, gi, bi  in  CBITS each  input colour
hsync_ext_n, vsync_ext_n, csync_ext_n  in  1 each  input syncs, active low
ro, go, bo  out  CBITS each  output colour
hsync, vsync  out  1 each  output syncs, active low
overflow  out  1  sticky: a line exceeded buffer depth

Behaviour:
- Reset: ro/go/bo=0, hsync=1, vsync=1, overflow=0. All counters are 0, wbank=0, and the output FSM is IDLE with line_len=0.
- Mode latch: enable_scandoubling and scan_mode are sampled only on an input hsync falling edge, so there are no torn lines.
- Edge detect: hsync_ext_n is registered every clk. A falling edge is prev=1, cur=0.
- Write side:
  - On clk14en with wcnt < 2^ADDR_BITS: write {r,g,b} to bank wbank at wcnt, then wcnt++. wcnt is ADDR_BITS+1 wide.
  - clk14en with wcnt = 2^ADDR_BITS: the pixel is dropped and overflow is set. overflow clears only on rst.
- On input hsync edge:
  - line_len <= wcnt, wbank toggles, wcnt <= 0.
  - The output FSM restarts at PASS0 with rcnt=0, even if it is mid-line.
  - If the edge coincides with clk14en, the edge wins. That pixel goes to address 0 of the new bank and wcnt becomes 1.
- Output FSM: IDLE -> PASS0 -> PASS1 -> IDLE.
  - Each pass reads bank ~wbank at rcnt, with rcnt incrementing every clk from 0 to line_len-1.
  - PASS0 moves to PASS1 at rcnt = line_len-1, and rcnt wraps to 0.
  - PASS1 moves to IDLE at line_len-1.
  - An edge with line_len=0 keeps the FSM in IDLE.
  - IDLE outputs colour 0 and hsync 1.
- Output hsync is low for the first min(HSYNC_WIDTH, line_len) clocks of each pass.
- Output vsync is vsync_ext_n passed through the same pipeline delay.
- Latency: 2 clk from rcnt to pins (1 clk synchronous RAM read + 1 clk output register). Syncs and blanking are delayed 2 clk to match.
- Dimming applies in PASS1 only, per channel, truncating:
  - 01: c - (c>>2)
  - 10: c>>1
  - 11: c>>2
  - PASS0 and 00 are unmodified.
- Bypass: ro/go/bo are the registered ri/gi/bi (1 clk), hsync is the registered csync_ext_n, and vsync=1. The line buffer keeps writing, but the output FSM is ignored.
- rst mid-line: the line is discarded and the next valid output starts two input edges later. The first edge only loads line_len.

Decomposition:
- Package vga_scandoubler_pkg holds:
  - scan_mode encodings SCAN_NONE/SCAN_25/SCAN_50/SCAN_75
  - FSM state enum IDLE/PASS0/PASS1
  - the dim function
- Sub-module scandbl_linebuf: simple dual-port RAM.
  - Depth 2^(ADDR_BITS+1) (bank bit is the MSB), width 3*CBITS.
  - Synchronous write on clk and registered read with 1 clk latency.
  - Infers block RAM.

Test Plan:
- Reset: hold rst 3 clk -> ro/go/bo=0, hsync=1, vsync=1, overflow=0. It stays idle with no hsync pulse until two input edges.
- Basic doubling (HSYNC_WIDTH=4, scan_mode=00): write 8 pixels ri=gi=bi=0..7 on alternate clk14en, then an hsync edge -> starting 2 clk after the edge, ro sequence 0..7 then 0..7. hsync is low for clocks 0-3 of each pass, then idle zeros.
- Dimming: repeat with pixel value 6 and modes 01/10/11 -> PASS1 ro = 5/3/1, PASS0 = 6. A mode change mid-line takes effect only after the next edge.
- Overflow (ADDR_BITS=4): 20 pixels then an edge -> line_len=16 and overflow=1 (sticky across later lines). Replay shows 16 pixels per pass.
- Coincident edge and clk14en: pixel value 5 arriving with the edge -> the next line's address 0 reads 5 and that line's line_len counts it. A short line (edge while in PASS1) restarts PASS0 immediately.
- Bypass: enable_scandoubling=0 latched at an edge -> ro = ri delayed 1 clk, hsync = csync_ext_n delayed 1 clk, vsync=1.
